fetch_decode_stage: RTL

- Front end of the 5-stage pipeline: PC register, instruction-memory addressing, and the IF/ID instruction register.
- Produces the decode fields (OPCODE, RD1, RD2) consumed by the pipeline controller.
- Holds the one-deep ID/EX shadow (PREV_DEST, PREV_REWR_MUX) that the controller uses for load-use detection.
- Obeys the controller's PC_WR/IR_WR stall, FLUSH and PCMUX redirect; also owns the retired-instruction counter and halt detection.

---
 rtl/fetch_decode_stage.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fetch_decode_stage.sv
// Pipeline front end: PC register, instruction-memory addressing, IF/ID
// instruction register, decode field slices, the one-deep ID/EX shadow used
// for load-use detection, retired-instruction counter and halt detection.
module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 12,
    parameter logic [31:0] HALT_W0  = 32'h00c0_0093,
    parameter logic [31:0] HALT_W1  = 32'h0000_8067
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic [31:0]        I_MEM_DI,
    output logic [IMEM_AW-1:0] I_MEM_ADDR,
    input  logic               PC_WR,
    input  logic               IR_WR,
    input  logic               FLUSH,
    input  logic               PCMUX,
    input  logic [31:0]        BR_TARGET,
    input  logic               NUMINSTADD,
    input  logic [1:0]         REWR_MUX_ID,
    output logic [31:0]        IF_ID_PC,
    output logic [31:0]        IF_ID_IR,
    output logic [6:0]         OPCODE,
    output logic [4:0]         RD1,
    output logic [4:0]         RD2,
    output logic [4:0]         PREV_DEST,
    output logic [1:0]         PREV_REWR_MUX,
    output logic [31:0]        NUM_INST,
    output logic               HALT
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        ARMED  = 2'd1,
        HALTED = 2'd2
    } halt_state_t;

    halt_state_t state;
    logic        halt_q;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] if_id_pc;
    logic [4:0]  prev_dest;
    logic [1:0]  prev_rewr_mux;
    logic [31:0] num_inst;
    logic        advance;
    logic [4:0]  ir_rd;

    // The ID instruction moves on only when the controller lets IR load and we are not halted
    assign advance = IR_WR & ~halt_q;
    assign ir_rd   = ir[11:7];

    assign I_MEM_ADDR    = pc[IMEM_AW-1:0];
    assign IF_ID_PC      = if_id_pc;
    assign IF_ID_IR      = ir;
    assign OPCODE        = ir[6:0];
    assign RD1           = ir[19:15];
    assign RD2           = ir[24:20];
    assign PREV_DEST     = prev_dest;
    assign PREV_REWR_MUX = prev_rewr_mux;
    assign NUM_INST      = num_inst;
    assign HALT          = halt_q;

    // PC: redirect beats sequential advance, stall holds, halt freezes everything
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pc <= RESET_PC;
        end else if (!halt_q) begin
            if (PCMUX) begin
                pc <= BR_TARGET;
            end else if (PC_WR) begin
                pc <= pc + 32'd4;
            end
        end
    end

    // IF/ID register: a flush inserts a zero bubble even while stalled
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ir       <= 32'd0;
            if_id_pc <= 32'd0;
        end else if (!halt_q) begin
            if (FLUSH) begin
                ir       <= 32'd0;
                if_id_pc <= 32'd0;
            end else if (advance) begin
                ir       <= I_MEM_DI;
                if_id_pc <= pc;
            end
        end
    end

    // ID/EX shadow: capture the departing instruction's rd, or push a bubble on a stall
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            prev_dest     <= 5'd0;
            prev_rewr_mux <= 2'd0;
        end else if (!halt_q) begin
            if (IR_WR) begin
                prev_dest     <= ir_rd;
                prev_rewr_mux <= (ir_rd == 5'd0) ? 2'd0 : REWR_MUX_ID;
            end else begin
                prev_dest     <= 5'd0;
                prev_rewr_mux <= 2'd0;
            end
        end
    end

    // Retired-instruction counter, saturating at all ones
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            num_inst <= 32'd0;
        end else if (NUMINSTADD && !halt_q && (num_inst != 32'hFFFF_FFFF)) begin
            num_inst <= num_inst + 32'd1;
        end
    end

    // Halt detector: watches the instruction leaving ID for the two-word halt pattern
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state  <= RUN;
            halt_q <= 1'b0;
        end else if (advance) begin
            case (state)
                RUN: begin
                    if (ir == HALT_W0) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (ir == HALT_W1) begin
                        state  <= HALTED;
                        halt_q <= 1'b1;
                    end else if (ir != HALT_W0) begin
                        state <= RUN;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule
